dmem_access_ctrl: RTL and testbench
===================================

// Module: dmem_access_ctrl
// PURPOSE
//  Load/store sequencer between the core MEM stage and the byte-lane data RAM (4x8-bit banks).
//  Accepts one RV32 load/store request, then drives the RAM word address, per-byte write enables and lane-aligned write data.
//  Sign/zero-extends load results. A misaligned access is split into two word accesses.
//  Requests are served one at a time.
// PARAMETERS
//  DEPTH_BITS       12  byte-address width of data RAM (RAM_DEPTH = 2^(DEPTH_BITS-2) words)
//  ALLOW_MISALIGNED 1   1: split word-crossing accesses; 0: flag them as errors, no RAM access
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   synchronous reset, active low
//  req_valid    in   1   request strobe
//  req_ready    out  1   high when a request can be accepted (state IDLE)
//  req_we       in   1   1=store, 0=load
//  req_funct3   in   3   RV32 funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data, right-justified
//  rsp_valid    out  1   one-cycle completion pulse
//  rsp_rdata    out  32  extended load data (0 for stores/errors)
//  rsp_err      out  1   illegal funct3 or disallowed misalign; qualified by rsp_valid
//  ram_addr     out  32  byte address to RAM, {word,2'b00}; bits >= DEPTH_BITS are 0
//  ram_wren     out  4   per-byte write enables
//  ram_wrdata   out  32  lane-aligned write data
//  ram_rddata   in   32  RAM read data, valid 1 cycle after ram_addr (registered read)
// BEHAVIOUR
//  Reset
//  - Outputs reset: req_ready=1 (state IDLE), rsp_valid=0, rsp_err=0, rsp_rdata=0, ram_wren=0, ram_addr=0, ram_wrdata=0.
//  - Reset mid-operation: next state IDLE, ram_wren=0 immediately. A half-done split store is not rolled back.
//  Outputs
//  - All RAM-side outputs and rsp_* are registered.
//  Request decode
//  - Size n = 1/2/4 from funct3[1:0]; byte offset off = req_addr[1:0].
//  - split = (off + n > 4).
//  - Illegal: funct3 in {3,6,7}; store with funct3 in {4,5}; split while ALLOW_MISALIGNED=0.
//  - An illegal request skips all RAM access: rsp_valid and rsp_err assert at T+1.
//  FSM: IDLE -> ACC0 -> [ACC1] -> [CAP] -> IDLE
//  - IDLE: req_ready=1. On req_valid, latch the request; next state is ACC0 (or err response).
//  - ACC0: ram_addr=word W. Store lanes = low half of 8-bit mask ({4'b0,bytemask}<<off).
//    Store data = low word of ({32'b0,wdata}<<8*off).
//    Next state: split ? ACC1 : (load ? CAP : IDLE with rsp_valid).
//  - ACC1: ram_addr=word W+1, wrapping mod RAM_DEPTH. Store lanes/data = high halves.
//    For a load, capture ram_rddata (word W) into lo.
//    Next state: load ? CAP : IDLE with rsp_valid.
//  - CAP: ram_wren=0. Shift {hi=ram_rddata, lo} right by 8*off; take n bytes.
//    Sign-extend for funct3 0/1, zero-extend for 4/5.
//    Next state IDLE with rsp_valid, rsp_rdata set.
//    Non-split: the single ram_rddata word is lo, hi=0.
//  - ram_wren is 0 in every state except store ACC0/ACC1.
//  Latency (accept at edge T)
//  - rsp_valid at T+2 (store), T+3 (load), T+3 (split store), T+4 (split load).
//  - rsp_valid occurs while in IDLE. A new request may be accepted in the same cycle as rsp_valid.
//  Other rules
//  - req_* inputs are ignored outside IDLE.
//  - The address bits above DEPTH_BITS are dropped (alias).
// TESTING
//  1 SW 0x11223344 @0x10, then LW @0x10:
//    wren=4'b1111, rsp_rdata=0x11223344, load rsp_valid at T+3.
//  2 SB 0x80 @0x13, then LB @0x13 -> wren=4'b1000, rsp=0xFFFFFF80.
//    LBU @0x13 -> rsp=0x00000080.
//  3 SW 0xAABBCCDD @0x21 (split):
//    ACC0 addr 0x20 wren=1110, data=0xBBCCDD00; ACC1 addr 0x24 wren=0001, data=0x000000AA.
//    LW @0x21 returns 0xAABBCCDD at T+4.
//  4 LH @0xFFF (DEPTH_BITS=12):
//    ACC1 ram_addr wraps to 0x000; result = {byte0@0x000, byte@0xFFF} sign-extended.
//  5 funct3=3 or SB with funct3=4 -> rsp_err=1 at T+1, ram_wren never asserted.
//    With ALLOW_MISALIGNED=0, LW @0x22 -> rsp_err=1.
//  6 rst_n low during ACC1 of a split store:
//    next cycle state IDLE, req_ready=1, ram_wren=0, rsp_valid=0; only the ACC0 bytes are written.

Source files
------------

// File: rtl/dmem_access_ctrl_if.sv
// Request/response and byte-lane RAM bus of the data-memory load/store sequencer.
// The master side drives requests and returns RAM read data; the slave side is the sequencer.
interface dmem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] ram_addr;
  logic [3:0]  ram_wren;
  logic [31:0] ram_wrdata;
  logic [31:0] ram_rddata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, ram_rddata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, ram_addr, ram_wren, ram_wrdata
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, ram_rddata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, ram_addr, ram_wren, ram_wrdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// RV32 load/store sequencer for a 4x8-bit byte-lane data RAM with registered read.
// Word-crossing accesses are split into two word accesses; load results are sign/zero-extended.
module dmem_access_ctrl #(
  parameter int unsigned DEPTH_BITS       = 12,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  dmem_access_ctrl_if.slave bus
);

  localparam int unsigned WB = DEPTH_BITS - 2;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, CAP} state_t;

  state_t state_q, state_d;

  logic          we_q, we_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    off_q, off_d;
  logic [WB-1:0] word_q, word_d;
  logic          split_q, split_d;
  logic [3:0]    mask_hi_q, mask_hi_d;
  logic [31:0]   data_hi_q, data_hi_d;
  logic [31:0]   lo_q, lo_d;

  logic [31:0] addr_q, addr_d;
  logic [3:0]  wren_q, wren_d;
  logic [31:0] wrdata_q, wrdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic [1:0]  d_off;
  logic [2:0]  d_nbytes;
  logic [3:0]  d_mask4;
  logic [7:0]  d_mask8;
  logic [63:0] d_data64;
  logic        d_split;
  logic        d_illegal;

  logic [63:0] cap_pair;
  logic [31:0] cap_word;
  logic [31:0] cap_ext;

  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[31:DEPTH_BITS];

  function automatic logic [31:0] word_to_addr(input logic [WB-1:0] w);
    logic [31:0] a;
    a = '0;
    a[DEPTH_BITS-1:0] = {w, 2'b00};
    return a;
  endfunction

  always_comb begin
    d_off = bus.req_addr[1:0];
    case (bus.req_funct3[1:0])
      2'd0:    begin d_nbytes = 3'd1; d_mask4 = 4'b0001; end
      2'd1:    begin d_nbytes = 3'd2; d_mask4 = 4'b0011; end
      default: begin d_nbytes = 3'd4; d_mask4 = 4'b1111; end
    endcase
    d_mask8   = {4'b0000, d_mask4} << d_off;
    d_data64  = {32'b0, bus.req_wdata} << {d_off, 3'b000};
    d_split   = ({1'b0, d_off} + d_nbytes) > 3'd4;
    d_illegal = (bus.req_funct3[1:0] == 2'b11) || (bus.req_funct3 == 3'd6) ||
                (bus.req_we && bus.req_funct3[2]) || (d_split && !ALLOW_MISALIGNED);
  end

  // A non-split load sees its only word in CAP, so it takes the low slot with hi forced to 0.
  always_comb begin
    cap_pair = split_q ? {bus.ram_rddata, lo_q} : {32'b0, bus.ram_rddata};
    cap_word = 32'(cap_pair >> {off_q, 3'b000});
    case (f3_q)
      3'd0:    cap_ext = {{24{cap_word[7]}}, cap_word[7:0]};
      3'd1:    cap_ext = {{16{cap_word[15]}}, cap_word[15:0]};
      3'd4:    cap_ext = {24'b0, cap_word[7:0]};
      3'd5:    cap_ext = {16'b0, cap_word[15:0]};
      default: cap_ext = cap_word;
    endcase
  end

  // RAM-side outputs are computed for the state being entered, then registered.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    f3_d        = f3_q;
    off_d       = off_q;
    word_d      = word_q;
    split_d     = split_q;
    mask_hi_d   = mask_hi_q;
    data_hi_d   = data_hi_q;
    lo_d        = lo_q;
    addr_d      = addr_q;
    wren_d      = '0;
    wrdata_d    = wrdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (d_illegal) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            we_d      = bus.req_we;
            f3_d      = bus.req_funct3;
            off_d     = d_off;
            word_d    = bus.req_addr[DEPTH_BITS-1:2];
            split_d   = d_split;
            mask_hi_d = d_mask8[7:4];
            data_hi_d = d_data64[63:32];
            addr_d    = word_to_addr(bus.req_addr[DEPTH_BITS-1:2]);
            if (bus.req_we) begin
              wren_d   = d_mask8[3:0];
              wrdata_d = d_data64[31:0];
            end
            state_d = ACC0;
          end
        end
      end
      ACC0: begin
        if (split_q) begin
          addr_d = word_to_addr(word_q + 1'b1);
          if (we_q) begin
            wren_d   = mask_hi_q;
            wrdata_d = data_hi_q;
          end
          state_d = ACC1;
        end else if (!we_q) begin
          state_d = CAP;
        end else begin
          rsp_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      ACC1: begin
        if (!we_q) begin
          lo_d    = bus.ram_rddata;
          state_d = CAP;
        end else begin
          rsp_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      CAP: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = cap_ext;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      f3_q        <= '0;
      off_q       <= '0;
      word_q      <= '0;
      split_q     <= 1'b0;
      mask_hi_q   <= '0;
      data_hi_q   <= '0;
      lo_q        <= '0;
      addr_q      <= '0;
      wren_q      <= '0;
      wrdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      word_q      <= word_d;
      split_q     <= split_d;
      mask_hi_q   <= mask_hi_d;
      data_hi_q   <= data_hi_d;
      lo_q        <= lo_d;
      addr_q      <= addr_d;
      wren_q      <= wren_d;
      wrdata_q    <= wrdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Asserting reset kills a pending write lane before the RAM's next edge samples it.
  assign bus.ram_wren   = wren_q & {4{rst_n}};
  assign bus.req_ready  = (state_q == IDLE);
  assign bus.ram_addr   = addr_q;
  assign bus.ram_wrdata = wrdata_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp_rdata  = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: byte-lane RAM model, byte-level reference memory and response scoreboard.
module tb_dmem_access_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_access_ctrl_if bus ();
  dmem_access_ctrl_if bus2 ();

  dmem_access_ctrl #(.DEPTH_BITS(12), .ALLOW_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  dmem_access_ctrl #(.DEPTH_BITS(12), .ALLOW_MISALIGNED(1'b0)) dut_strict (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave)
  );

  assign bus2.ram_rddata = '0;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int unsigned due;
  } exp_t;

  exp_t sb[$];

  logic [7:0] mem    [0:4095] = '{default: 8'h00};
  logic [7:0] shadow [0:4095] = '{default: 8'h00};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Registered-read byte-lane RAM
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (bus.ram_wren[i]) mem[{bus.ram_addr[11:2], i[1:0]}] <= bus.ram_wrdata[8*i +: 8];
    bus.ram_rddata <= {mem[{bus.ram_addr[11:2], 2'd3}], mem[{bus.ram_addr[11:2], 2'd2}],
                       mem[{bus.ram_addr[11:2], 2'd1}], mem[{bus.ram_addr[11:2], 2'd0}]};
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus.rsp_valid) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
        check("rsp_rdata", bus.rsp_rdata, e.rdata);
        check("rsp_latency", cyc, e.due);
      end
    end
  end

  function automatic int unsigned nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic is_illegal(input logic we, input logic [2:0] f3);
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && (f3 == 3'd4 || f3 == 3'd5));
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] v;
    logic [11:0] a;
    v = '0;
    for (int i = 0; i < int'(nbytes(f3)); i++) begin
      a = addr[11:0] + 12'(i);
      v[8*i +: 8] = shadow[a];
    end
    case (f3)
      3'd0: v = {{24{v[7]}}, v[7:0]};
      3'd1: v = {{16{v[15]}}, v[15:0]};
      default: ;
    endcase
    return v;
  endfunction

  task automatic issue_raw(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic e_err, input logic [31:0] e_rdata,
                           input int unsigned lat);
    exp_t e;
    int unsigned n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) check("ready_timeout", 32'd0, 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    e.err   = e_err;
    e.rdata = e_rdata;
    e.due   = cyc + lat;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic op(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    logic        ill;
    logic        split;
    int unsigned n;
    int unsigned lat;
    logic [31:0] exp_rd;
    logic [11:0] a;
    ill   = is_illegal(we, f3);
    n     = nbytes(f3);
    split = (int'(addr[1:0]) + int'(n)) > 4;
    exp_rd = '0;
    if (ill) lat = 1;
    else if (we) lat = split ? 3 : 2;
    else lat = split ? 4 : 3;
    if (!ill && !we) exp_rd = model_load(f3, addr);
    if (!ill && we)
      for (int i = 0; i < int'(n); i++) begin
        a = addr[11:0] + 12'(i);
        shadow[a] = wdata[8*i +: 8];
      end
    issue_raw(we, f3, addr, wdata, ill, exp_rd, lat);
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic [2:0]  f3;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_funct3 = '0; bus2.req_addr = '0; bus2.req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_wren", 32'(bus.ram_wren), 32'd0);
    check("rst_ram_addr", bus.ram_addr, 32'd0);
    check("rst_wrdata", bus.ram_wrdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // aligned word store then load
    op(1'b1, 3'd2, 32'h10, 32'h11223344);
    check("t1_wren", 32'(bus.ram_wren), 32'h0000000F);
    check("t1_addr", bus.ram_addr, 32'h10);
    check("t1_wrdata", bus.ram_wrdata, 32'h11223344);
    issue_raw(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'h11223344, 3);
    drain();

    // byte store, signed and unsigned byte load
    op(1'b1, 3'd0, 32'h13, 32'h80);
    check("t2_wren", 32'(bus.ram_wren), 32'h8);
    check("t2_wrdata", bus.ram_wrdata, 32'h80000000);
    issue_raw(1'b0, 3'd0, 32'h13, 32'h0, 1'b0, 32'hFFFFFF80, 3);
    issue_raw(1'b0, 3'd4, 32'h13, 32'h0, 1'b0, 32'h00000080, 3);
    drain();

    // split word store and load
    op(1'b1, 3'd2, 32'h21, 32'hAABBCCDD);
    check("t3_acc0_addr", bus.ram_addr, 32'h20);
    check("t3_acc0_wren", 32'(bus.ram_wren), 32'hE);
    check("t3_acc0_data", bus.ram_wrdata, 32'hBBCCDD00);
    @(posedge clk); #1;
    check("t3_acc1_addr", bus.ram_addr, 32'h24);
    check("t3_acc1_wren", 32'(bus.ram_wren), 32'h1);
    check("t3_acc1_data", bus.ram_wrdata, 32'h000000AA);
    issue_raw(1'b0, 3'd2, 32'h21, 32'h0, 1'b0, 32'hAABBCCDD, 4);
    issue_raw(1'b0, 3'd2, 32'hABCD1021, 32'h0, 1'b0, 32'hAABBCCDD, 4);
    check("alias_addr", bus.ram_addr, 32'h20);
    drain();

    // halfword load wrapping the top of RAM
    op(1'b1, 3'd0, 32'h000, 32'hA5);
    op(1'b1, 3'd0, 32'hFFF, 32'hC3);
    issue_raw(1'b0, 3'd1, 32'hFFF, 32'h0, 1'b0, 32'hFFFFA5C3, 4);
    check("t4_acc0_addr", bus.ram_addr, 32'hFFC);
    @(posedge clk); #1;
    check("t4_acc1_addr", bus.ram_addr, 32'h000);
    drain();

    // illegal requests
    issue_raw(1'b0, 3'd3, 32'h40, 32'h0, 1'b1, 32'h0, 1);
    check("t5_f3_wren0", 32'(bus.ram_wren), 32'h0);
    check("t5_f3_ready", 32'(bus.req_ready), 32'd1);
    issue_raw(1'b1, 3'd4, 32'h40, 32'h12, 1'b1, 32'h0, 1);
    check("t5_sbu_wren0", 32'(bus.ram_wren), 32'h0);
    @(posedge clk); #1;
    check("t5_sbu_wren0_b", 32'(bus.ram_wren), 32'h0);
    drain();
    @(negedge clk);
    bus2.req_valid = 1'b1; bus2.req_we = 1'b0; bus2.req_funct3 = 3'd2; bus2.req_addr = 32'h22;
    @(posedge clk); #1;
    bus2.req_valid = 1'b0;
    check("t5_strict_valid", 32'(bus2.rsp_valid), 32'd1);
    check("t5_strict_err", 32'(bus2.rsp_err), 32'd1);
    check("t5_strict_wren", 32'(bus2.ram_wren), 32'h0);
    @(negedge clk);
    bus2.req_valid = 1'b1; bus2.req_addr = 32'h20;
    @(posedge clk); #1;
    bus2.req_valid = 1'b0;
    check("t5_strict_ok_valid", 32'(bus2.rsp_valid), 32'd0);
    check("t5_strict_ok_addr", bus2.ram_addr, 32'h20);
    repeat (4) @(posedge clk);

    // reset during ACC1 of a split store
    op(1'b1, 3'd2, 32'h40, 32'h0);
    op(1'b1, 3'd2, 32'h44, 32'h0);
    drain();
    issue_raw(1'b1, 3'd2, 32'h42, 32'h11223344, 1'b0, 32'h0, 3);
    @(posedge clk); #1;
    check("t6_acc1_wren", 32'(bus.ram_wren), 32'h3);
    rst_n = 1'b0;
    #1;
    check("t6_wren_gated", 32'(bus.ram_wren), 32'h0);
    @(posedge clk); #1;
    check("t6_ready", 32'(bus.req_ready), 32'd1);
    check("t6_wren", 32'(bus.ram_wren), 32'h0);
    check("t6_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    sb.delete();
    shadow[12'h042] = 8'h44;
    shadow[12'h043] = 8'h33;
    @(negedge clk);
    rst_n = 1'b1;
    issue_raw(1'b0, 3'd2, 32'h40, 32'h0, 1'b0, 32'h33440000, 3);
    issue_raw(1'b0, 3'd2, 32'h44, 32'h0, 1'b0, 32'h00000000, 3);
    drain();

    // random mix checked against the byte-level reference
    for (int k = 0; k < 60; k++) begin
      r  = $urandom();
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) r = r & 32'hFFFF_FFFF;
      else r = r & 32'h0000_0FFF;
      op(1'($urandom_range(0, 1)), f3, r, $urandom());
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
